// File: rtl/inst_fetch_unit_if.sv
// Core-side fetch handshake and byte-wide instruction memory bus of the fetch unit.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 17
);
    logic              req_i;
    logic [31:0]       addr_i;
    logic              flush_i;
    logic [31:0]       inst_o;
    logic              inst_valid_o;
    logic              busy_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic              mem_rd_o;
    logic [7:0]        mem_din_i;

    // Fetch unit side
    modport slave (
        input  req_i, addr_i, flush_i, mem_din_i,
        output inst_o, inst_valid_o, busy_o, mem_a_o, mem_rd_o
    );

    // Core / memory side
    modport master (
        output req_i, addr_i, flush_i, mem_din_i,
        input  inst_o, inst_valid_o, busy_o, mem_a_o, mem_rd_o
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: turns a 32-bit word fetch into four byte reads on an
// 8-bit instruction bus, assembles the little-endian word, and keeps a
// one-entry word buffer so a repeated fetch of the same word returns in one cycle.
module inst_fetch_unit #(
    parameter int ADDR_W = 17,
    parameter int INST_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [1:0]        k;
    logic [31:2]       base_q;
    logic [INST_W-1:0] word_acc;
    logic              buf_valid;
    logic [31:2]       buf_addr;
    logic [INST_W-1:0] buf_data;
    logic [INST_W-1:0] inst_q;
    logic              inst_valid_q;
    logic              busy_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic              mem_rd_q;

    logic              accept;
    logic              hit;
    logic [INST_W-1:0] assembled;
    logic              unused_addr_lsbs;

    assign accept           = bus.req_i && !bus.flush_i;
    assign hit              = buf_valid && (bus.addr_i[31:2] == buf_addr);
    // Bytes arrive lowest first and shift down, so the last byte lands on top.
    assign assembled        = {bus.mem_din_i, word_acc[INST_W-1:8]};
    assign unused_addr_lsbs = ^bus.addr_i[1:0];

    assign bus.inst_o       = inst_q;
    assign bus.inst_valid_o = inst_valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.mem_a_o      = mem_a_q;
    assign bus.mem_rd_o     = mem_rd_q;

    // Fetch FSM: byte issue/capture sequencing, word buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= 2'd0;
            base_q       <= '0;
            word_acc     <= '0;
            buf_valid    <= 1'b0;
            buf_addr     <= '0;
            buf_data     <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            mem_a_q      <= '0;
            mem_rd_q     <= 1'b0;
        end else begin
            inst_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            inst_q       <= buf_data;
                            inst_valid_q <= 1'b1;
                        end else begin
                            base_q   <= bus.addr_i[31:2];
                            mem_a_q  <= {bus.addr_i[ADDR_W-1:2], 2'b00};
                            mem_rd_q <= 1'b1;
                            busy_q   <= 1'b1;
                            k        <= 2'd0;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.flush_i) begin
                        mem_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        // Data on the bus belongs to the address issued last cycle;
                        // nothing valid is there yet while the first byte is issued.
                        if (k != 2'd0) begin
                            word_acc <= assembled;
                        end
                        if (k == 2'd3) begin
                            mem_rd_q <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            k       <= k + 2'd1;
                            mem_a_q <= {base_q[ADDR_W-1:2], k + 2'd1};
                        end
                    end
                end
                DRAIN: begin
                    if (bus.flush_i) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        inst_q       <= assembled;
                        inst_valid_q <= 1'b1;
                        buf_valid    <= 1'b1;
                        buf_addr     <= base_q;
                        buf_data     <= assembled;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // The pulse and buffer update already happened; a flush here
                    // changes nothing, the core simply drops the word.
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    mem_rd_q <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a small registered byte-memory model.
module tb_inst_fetch_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    inst_fetch_unit_if #(.ADDR_W(17)) bus ();

    inst_fetch_unit #(.ADDR_W(17), .INST_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [16:0] a);
        case (a)
            17'h01000: mem_byte = 8'h13;
            17'h01001: mem_byte = 8'h05;
            17'h01002: mem_byte = 8'h10;
            17'h01003: mem_byte = 8'h00;
            17'h02000: mem_byte = 8'h11;
            17'h02001: mem_byte = 8'h22;
            17'h02002: mem_byte = 8'h33;
            17'h02003: mem_byte = 8'h44;
            17'h1FFFC: mem_byte = 8'hAA;
            17'h1FFFD: mem_byte = 8'hBB;
            17'h1FFFE: mem_byte = 8'hCC;
            17'h1FFFF: mem_byte = 8'hDD;
            default:   mem_byte = 8'h00;
        endcase
    endfunction

    // Memory returns the byte for the address presented in the previous cycle.
    always @(posedge clk) bus.mem_din_i <= mem_byte(bus.mem_a_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full miss: accept, four byte issues, drain, valid pulse, back to idle.
    task automatic run_miss(input string tag, input logic [31:0] addr,
                            input logic [16:0] exp_a0, input logic [31:0] exp_w);
        logic [16:0] ea;
        bus.req_i  = 1'b1;
        bus.addr_i = addr;
        step();
        bus.req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ea = exp_a0 + 17'(i);
            check({tag, "_mem_a"}, 32'(bus.mem_a_o), 32'(ea));
            check({tag, "_mem_rd"}, 32'(bus.mem_rd_o), 32'd1);
            check({tag, "_busy_issue"}, 32'(bus.busy_o), 32'd1);
            check({tag, "_no_early_valid"}, 32'(bus.inst_valid_o), 32'd0);
            step();
        end
        check({tag, "_drain_rd"}, 32'(bus.mem_rd_o), 32'd0);
        check({tag, "_drain_busy"}, 32'(bus.busy_o), 32'd1);
        check({tag, "_drain_valid"}, 32'(bus.inst_valid_o), 32'd0);
        step();
        check({tag, "_valid"}, 32'(bus.inst_valid_o), 32'd1);
        check({tag, "_inst"}, bus.inst_o, exp_w);
        check({tag, "_done_busy"}, 32'(bus.busy_o), 32'd1);
        step();
        check({tag, "_valid_drop"}, 32'(bus.inst_valid_o), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_inst_hold"}, bus.inst_o, exp_w);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_mem_rd"}, 32'(bus.mem_rd_o), 32'd0);
        check({tag, "_valid"}, 32'(bus.inst_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.req_i   = 1'b0;
        bus.addr_i  = 32'h0;
        bus.flush_i = 1'b0;
        step();
        step();
        check("rst_inst", bus.inst_o, 32'h0);
        check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_mem_a", 32'(bus.mem_a_o), 32'h0);
        check("rst_mem_rd", 32'(bus.mem_rd_o), 32'd0);
        rst = 1'b0;
        step();

        // Miss on 0x1000
        run_miss("miss1000", 32'h0000_1000, 17'h01000, 32'h0010_0513);

        // Buffer hit with misaligned address in the same word
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_1002;
        step();
        bus.req_i = 1'b0;
        check("hit_valid", 32'(bus.inst_valid_o), 32'd1);
        check("hit_inst", bus.inst_o, 32'h0010_0513);
        check("hit_mem_rd", 32'(bus.mem_rd_o), 32'd0);
        check("hit_busy", 32'(bus.busy_o), 32'd0);
        step();
        check("hit_valid_drop", 32'(bus.inst_valid_o), 32'd0);

        // Flush mid-fetch on 0x2000, flush during T+3
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_2000;
        step();
        bus.req_i = 1'b0;
        step();
        step();
        check("flush_mem_a_t3", 32'(bus.mem_a_o), 32'h2002);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check_quiet("flush_t4");
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush_no_valid", 32'(bus.inst_valid_o), 32'd0);
        end
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_1000;
        step();
        bus.req_i = 1'b0;
        check("post_flush_hit_valid", 32'(bus.inst_valid_o), 32'd1);
        check("post_flush_hit_inst", bus.inst_o, 32'h0010_0513);
        check("post_flush_hit_rd", 32'(bus.mem_rd_o), 32'd0);
        step();

        // Simultaneous req and flush in IDLE: nothing accepted
        bus.req_i   = 1'b1;
        bus.flush_i = 1'b1;
        bus.addr_i  = 32'h0000_3000;
        step();
        check_quiet("reqflush_c1");
        step();
        bus.req_i   = 1'b0;
        bus.flush_i = 1'b0;
        check_quiet("reqflush_c2");
        step();

        // Reset mid-fetch of 0x2000, asserted in T+2
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_2000;
        step();
        bus.req_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_inst", bus.inst_o, 32'h0);
        check("midrst_valid", 32'(bus.inst_valid_o), 32'd0);
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        check("midrst_mem_a", 32'(bus.mem_a_o), 32'h0);
        check("midrst_mem_rd", 32'(bus.mem_rd_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("midrst_no_valid", 32'(bus.inst_valid_o), 32'd0);
        end

        // Buffer was cleared by reset, so 0x1000 is a full miss again
        run_miss("refetch1000", 32'h0000_1000, 17'h01000, 32'h0010_0513);

        // Complete miss on 0x2000
        run_miss("miss2000", 32'h0000_2000, 17'h02000, 32'h4433_2211);

        // Address at the top of the 17-bit space
        run_miss("wrap", 32'h0001_FFFC, 17'h1FFFC, 32'hDDCC_BBAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
